// File: rtl/regfile_dump.sv
// regfile_dump: walks a window of register-file entries and streams each value
// out as a valid/ready beat tagged with its index. The read port is combinational,
// so each register is sampled on the cycle its beat is loaded into the output register.
//
// state | meaning
// IDLE  | waiting for start; raddr parked at 0
// RUN   | reads still to issue; output register refills on empty or on handshake
// DRAIN | every read issued; waiting for the final beat to be accepted
module regfile_dump #(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [$clog2(N)-1:0]   first_idx,
  input  logic [$clog2(N):0]     count,
  input  logic                   abort,
  output logic [$clog2(N)-1:0]   raddr,
  input  logic [W-1:0]           rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cur_idx;
  logic [CW-1:0] remaining;
  logic [CW-1:0] count_clamped;
  logic          hs;
  logic          load;
  logic          final_load;

  assign count_clamped = (count > N_CNT) ? N_CNT : count;
  assign hs            = out_valid & out_ready;
  // abort wins over any load or handshake in the same cycle
  assign load          = (state == RUN) & (~out_valid | hs) & ~abort;
  assign final_load    = load & (remaining == CW'(1));
  assign raddr         = (state == RUN) ? cur_idx : '0;
  assign busy          = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && (count_clamped != '0)) state_nxt = RUN;
      end
      RUN: begin
        if (abort)           state_nxt = IDLE;
        else if (final_load) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort || hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Walk pointer, beat register and done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_idx   <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_idx   <= first_idx;
            remaining <= count_clamped;
            // an empty request completes immediately without emitting a beat
            if (count_clamped == '0) done <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (load) begin
            out_data  <= rdata;
            out_idx   <= cur_idx;
            out_valid <= 1'b1;
            out_last  <= (remaining == CW'(1));
            cur_idx   <= (cur_idx == LAST_IDX) ? '0 : cur_idx + AW'(1);
            remaining <= remaining - CW'(1);
          end
        end
        DRAIN: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
